eprisc_busmaster: RTL and testbench



---
 rtl/eprisc_busmaster_if.sv | 21 ++
 rtl/eprisc_busmaster.sv | 182 ++++++++++++++++++
 tb/tb_eprisc_busmaster.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eprisc_busmaster_if.sv
// Wide-SPI system bus between the epRISC bus master and the I/O controller.
interface eprisc_busmaster_if #(
    parameter int unsigned LANES     = 8,
    parameter int unsigned SEL_WIDTH = 2
);
    logic                 oBusClock;
    logic [SEL_WIDTH-1:0] oBusSelect;
    logic [LANES-1:0]     oBusMOSI;
    logic [LANES-1:0]     iBusMISO;
    logic                 iBusInterrupt;

    modport master (
        output oBusClock, oBusSelect, oBusMOSI,
        input  iBusMISO, iBusInterrupt
    );

    modport slave (
        input  oBusClock, oBusSelect, oBusMOSI,
        output iBusMISO, iBusInterrupt
    );
endinterface

// File: rtl/eprisc_busmaster.sv
// epRISC wide-SPI bus master: full-duplex word transfer, LANES bits per bus clock,
// optional burst hold of select, and a synchronised, latched device interrupt.
module eprisc_busmaster #(
    parameter int unsigned WORD_BITS = 32,
    parameter int unsigned LANES     = 8,
    parameter int unsigned SEL_WIDTH = 2,
    parameter int unsigned DIVIDER   = 4
) (
    input  logic                 iBoardClock,
    input  logic                 iBoardReset,
    input  logic                 iStart,
    input  logic [SEL_WIDTH-1:0] iDevice,
    input  logic [WORD_BITS-1:0] iData,
    input  logic                 iHold,
    input  logic                 iIntClear,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [WORD_BITS-1:0] oData,
    output logic                 oIntPending,
    eprisc_busmaster_if.master   bus
);

    localparam int unsigned BEATS  = WORD_BITS / LANES;
    localparam int unsigned CNT_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HELD, S_RELEASE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [BEAT_W-1:0]    r_beat;
    logic [WORD_BITS-1:0] r_tx;
    logic [WORD_BITS-1:0] r_rx;
    logic [WORD_BITS-1:0] r_data;
    logic [SEL_WIDTH-1:0] r_sel;
    logic [SEL_WIDTH-1:0] r_dev;
    logic [LANES-1:0]     r_mosi;
    logic                 r_bclk;
    logic                 r_hold;
    logic                 r_reload;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_sync3;
    logic                 r_int;
    logic                 w_phase_end;

    assign w_phase_end = (r_cnt == CNT_W'(DIVIDER - 1));

    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_beat   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_data   <= '0;
            r_sel    <= '0;
            r_dev    <= '0;
            r_mosi   <= '0;
            r_bclk   <= 1'b0;
            r_hold   <= 1'b0;
            r_reload <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_HELD: begin
                    if (iStart) begin
                        r_hold <= iHold;
                        r_dev  <= iDevice;
                        r_cnt  <= '0;
                        r_beat <= '0;
                        r_busy <= 1'b1;
                        // Switching devices mid-burst needs a deselect gap first
                        if (r_state == S_HELD && iDevice != r_sel) begin
                            r_sel    <= '0;
                            r_mosi   <= '0;
                            r_tx     <= iData;
                            r_reload <= 1'b1;
                            r_state  <= S_RELEASE;
                        end else begin
                            r_sel   <= iDevice;
                            r_mosi  <= iData[WORD_BITS-1 -: LANES];
                            r_tx    <= iData << LANES;
                            r_state <= S_SETUP;
                        end
                    end
                end
                S_SETUP, S_LOW: begin
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_bclk  <= 1'b1;
                        r_rx    <= WORD_BITS'({r_rx, bus.iBusMISO});
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_phase_end) begin
                        r_cnt  <= '0;
                        r_bclk <= 1'b0;
                        if (r_beat == BEAT_W'(BEATS - 1)) begin
                            r_data <= r_rx;
                            r_done <= 1'b1;
                            if (r_hold) begin
                                r_busy  <= 1'b0;
                                r_state <= S_HELD;
                            end else begin
                                r_sel    <= '0;
                                r_mosi   <= '0;
                                r_reload <= 1'b0;
                                r_state  <= S_RELEASE;
                            end
                        end else begin
                            r_beat  <= r_beat + BEAT_W'(1);
                            r_mosi  <= r_tx[WORD_BITS-1 -: LANES];
                            r_tx    <= r_tx << LANES;
                            r_state <= S_LOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        if (r_reload) begin
                            r_reload <= 1'b0;
                            r_sel    <= r_dev;
                            r_mosi   <= r_tx[WORD_BITS-1 -: LANES];
                            r_tx     <= r_tx << LANES;
                            r_state  <= S_SETUP;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt: 2-flop synchroniser, rising-edge detect; a new edge beats a clear
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            r_sync1 <= bus.iBusInterrupt;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_sync2 && !r_sync3) begin
                r_int <= 1'b1;
            end else if (iIntClear) begin
                r_int <= 1'b0;
            end
        end
    end

    assign oBusy          = r_busy;
    assign oDone          = r_done;
    assign oData          = r_data;
    assign oIntPending    = r_int;
    assign bus.oBusClock  = r_bclk;
    assign bus.oBusSelect = r_sel;
    assign bus.oBusMOSI   = r_mosi;

endmodule

// File: tb/tb_eprisc_busmaster.sv
// Self-checking bench for eprisc_busmaster: default 32/8/D4 instance plus a 16/4/D1 instance.
module tb_eprisc_busmaster;

    localparam int unsigned W  = 32;
    localparam int unsigned L  = 8;
    localparam int unsigned SW = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned B  = W / L;
    localparam int unsigned W2 = 16;
    localparam int unsigned L2 = 4;
    localparam int unsigned D2 = 1;
    localparam int unsigned B2 = W2 / L2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start_a = 1'b0, hold_a = 1'b0, iclr_a = 1'b0;
    logic [SW-1:0] dev_a = '0;
    logic [W-1:0]  din_a = '0;
    logic          busy_a, done_a, intp_a;
    logic [W-1:0]  dout_a;

    logic          start_b = 1'b0, hold_b = 1'b0, iclr_b = 1'b0;
    logic [SW-1:0] dev_b = '0;
    logic [W2-1:0] din_b = '0;
    logic          busy_b, done_b, intp_b;
    logic [W2-1:0] dout_b;

    eprisc_busmaster_if #(.LANES(L),  .SEL_WIDTH(SW)) bus_a ();
    eprisc_busmaster_if #(.LANES(L2), .SEL_WIDTH(SW)) bus_b ();

    eprisc_busmaster #(.WORD_BITS(W), .LANES(L), .SEL_WIDTH(SW), .DIVIDER(D)) dut_a (
        .iBoardClock(clk), .iBoardReset(rst), .iStart(start_a), .iDevice(dev_a),
        .iData(din_a), .iHold(hold_a), .iIntClear(iclr_a), .oBusy(busy_a),
        .oDone(done_a), .oData(dout_a), .oIntPending(intp_a), .bus(bus_a.master)
    );

    eprisc_busmaster #(.WORD_BITS(W2), .LANES(L2), .SEL_WIDTH(SW), .DIVIDER(D2)) dut_b (
        .iBoardClock(clk), .iBoardReset(rst), .iStart(start_b), .iDevice(dev_b),
        .iData(din_b), .iHold(hold_b), .iIntClear(iclr_b), .oBusy(busy_b),
        .oDone(done_b), .oData(dout_b), .oIntPending(intp_b), .bus(bus_b.master)
    );

    int errors = 0;
    int checks = 0;
    logic [SW-1:0] m_held = '0;   // device still selected by a held burst, 0 if none

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word on instance A; expected waveform derived from the timing rules per cycle
    task automatic run_word(input logic [SW-1:0] d, input logic [W-1:0] w, input logic h,
                            input logic [W-1:0] mw, input int poke_at);
        int gap, total, m, j, waitn;
        logic [12:0] exp_v, act_v;
        logic e_clk, e_done, e_busy;
        logic [SW-1:0] e_sel;
        logic [L-1:0] e_mosi;
        gap   = (m_held != '0 && m_held != d) ? int'(D) : 0;
        waitn = 0;
        while (busy_a && waitn < 200) begin
            tick();
            waitn++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL run_word_idle_wait busy=%b want 0", busy_a);
        end
        bus_a.iBusMISO = mw[W-1 -: L];
        start_a = 1'b1; dev_a = d; din_a = w; hold_a = h;
        tick();
        start_a = 1'b0;
        total = gap + int'(2*D*B) + (h ? 0 : int'(D));
        for (int n = 0; n <= total; n++) begin
            m = n - gap;
            if (n == poke_at) begin
                start_a = 1'b1; din_a = ~w; dev_a = d ^ 2'b11;
            end else begin
                start_a = 1'b0;
            end
            e_clk = 1'b0; e_done = 1'b0; e_busy = 1'b1; e_sel = '0; e_mosi = '0;
            if (m >= 0 && m < int'(2*D*B)) begin
                j      = m / int'(2*D);
                e_sel  = d;
                e_clk  = (m % int'(2*D)) >= int'(D);
                e_mosi = w[W-1-j*L -: L];
            end else if (m == int'(2*D*B)) begin
                e_done = 1'b1;
                e_busy = !h;
                e_sel  = h ? d : '0;
                e_mosi = h ? w[L-1:0] : '0;
            end else if (m > int'(2*D*B)) begin
                e_busy = (m < int'(2*D*B + D));
            end
            exp_v = {e_clk, e_sel, e_mosi, e_done, e_busy};
            act_v = {bus_a.oBusClock, bus_a.oBusSelect, bus_a.oBusMOSI, done_a, busy_a};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL run_word cycle=%0d dev=%0d clk/sel/mosi/done/busy got %h want %h",
                         n, d, act_v, exp_v);
            end
            if (m == int'(2*D*B)) begin
                checks++;
                if (dout_a !== mw) begin
                    errors++;
                    $display("FAIL run_word_odata got %h want %h", dout_a, mw);
                end
            end
            if (m >= 0) begin
                j = (m < int'(D)) ? 0 : (m - int'(D)) / int'(2*D) + 1;
                if (j > int'(B) - 1) j = int'(B) - 1;
                bus_a.iBusMISO = mw[W-1-j*L -: L];
            end
            tick();
        end
        start_a = 1'b0;
        m_held = h ? d : '0;
    endtask

    task automatic test_reset();
        logic [W+W2+2*L2+20:0] act;
        rst = 1'b1;
        tick(); tick(); tick();
        act = {busy_a, done_a, dout_a, intp_a, bus_a.oBusClock, bus_a.oBusSelect, bus_a.oBusMOSI,
               busy_b, done_b, dout_b, intp_b, bus_b.oBusClock, bus_b.oBusSelect, bus_b.oBusMOSI};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", act);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_word(2'd1, 32'h12345678, 1'b0, 32'hAABBCCDD, -1);
    endtask

    task automatic test_back_to_back();
        run_word(2'd2, 32'hCAFEF00D, 1'b1, 32'h01020304, -1);
        run_word(2'd2, 32'h0BADBEEF, 1'b1, 32'hF0E0D0C0, -1);
        run_word(2'd1, 32'h5A5AA5A5, 1'b0, 32'h13579BDF, -1);
    endtask

    task automatic test_ignore_start();
        run_word(2'd3, 32'h89ABCDEF, 1'b0, 32'h76543210, 10);
    endtask

    task automatic test_reset_mid();
        logic [W+L+SW+3:0] act;
        start_a = 1'b1; dev_a = 2'd1; din_a = 32'hDEADBEEF; hold_a = 1'b0;
        bus_a.iBusMISO = 8'h11;
        tick();
        start_a = 1'b0;
        for (int n = 0; n < int'(3*D) - 1; n++) tick();
        rst = 1'b1;
        tick();
        act = {busy_a, done_a, dout_a, intp_a, bus_a.oBusClock, bus_a.oBusSelect, bus_a.oBusMOSI};
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 0", act);
        end
        rst = 1'b0;
        for (int n = 0; n < int'(2*D*B + D); n++) begin
            tick();
            checks++;
            if ({done_a, busy_a} !== 2'b00) begin
                errors++;
                $display("FAIL reset_mid_quiet cycle=%0d done/busy got %b want 00", n, {done_a, busy_a});
            end
        end
        m_held = '0;
        run_word(2'd1, 32'h0F1E2D3C, 1'b0, 32'h4B5A6978, -1);
    endtask

    task automatic test_random();
        logic [SW-1:0] d;
        logic h;
        logic [W-1:0] w, mw;
        for (int i = 0; i < 8; i++) begin
            d  = SW'($urandom_range(1, 3));
            h  = 1'($urandom_range(0, 1));
            w  = $urandom;
            mw = $urandom;
            run_word(d, w, h, mw, -1);
        end
        run_word(2'd3, $urandom, 1'b0, $urandom, -1);
    endtask

    task automatic test_interrupt();
        bus_a.iBusInterrupt = 1'b1;
        tick();
        bus_a.iBusInterrupt = 1'b0;
        tick();
        checks++;
        if (intp_a !== 1'b0) begin errors++; $display("FAIL int_early got %b want 0", intp_a); end
        tick();
        checks++;
        if (intp_a !== 1'b1) begin errors++; $display("FAIL int_latency got %b want 1", intp_a); end
        bus_a.iBusInterrupt = 1'b1;
        tick();
        bus_a.iBusInterrupt = 1'b0;
        tick();
        iclr_a = 1'b1;
        tick();
        iclr_a = 1'b0;
        checks++;
        if (intp_a !== 1'b1) begin errors++; $display("FAIL int_set_wins got %b want 1", intp_a); end
        iclr_a = 1'b1;
        tick();
        iclr_a = 1'b0;
        checks++;
        if (intp_a !== 1'b0) begin errors++; $display("FAIL int_clear got %b want 0", intp_a); end
        bus_a.iBusInterrupt = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (intp_a !== 1'b1) begin errors++; $display("FAIL int_level_set got %b want 1", intp_a); end
        iclr_a = 1'b1;
        tick();
        iclr_a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            checks++;
            if (intp_a !== 1'b0) begin
                errors++;
                $display("FAIL int_level_once cycle=%0d got %b want 0", n, intp_a);
            end
        end
        bus_a.iBusInterrupt = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_narrow();
        logic [W2-1:0] w, mw;
        logic [L2+3:0] exp_v, act_v;
        int j;
        w  = 16'hBEEF;
        mw = 16'hC3A5;
        bus_b.iBusMISO = mw[W2-1 -: L2];
        start_b = 1'b1; dev_b = 2'd3; din_b = w; hold_b = 1'b0;
        tick();
        start_b = 1'b0;
        for (int n = 0; n <= int'(2*D2*B2 + D2); n++) begin
            if (n < int'(2*D2*B2)) begin
                j = n / int'(2*D2);
                exp_v = {(n % int'(2*D2)) >= int'(D2), w[W2-1-j*L2 -: L2], 1'b0, 1'b1};
            end else if (n == int'(2*D2*B2)) begin
                exp_v = {1'b0, 4'h0, 1'b1, 1'b1};
            end else begin
                exp_v = {1'b0, 4'h0, 1'b0, 1'b0};
            end
            act_v = {bus_b.oBusClock, bus_b.oBusMOSI, done_b, busy_b};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL narrow cycle=%0d clk/mosi/done/busy got %h want %h", n, act_v, exp_v);
            end
            if (n == int'(2*D2*B2)) begin
                checks++;
                if (dout_b !== mw) begin
                    errors++;
                    $display("FAIL narrow_odata got %h want %h", dout_b, mw);
                end
            end
            j = (n < int'(D2)) ? 0 : (n - int'(D2)) / int'(2*D2) + 1;
            if (j > int'(B2) - 1) j = int'(B2) - 1;
            bus_b.iBusMISO = mw[W2-1-j*L2 -: L2];
            tick();
        end
    endtask

    initial begin
        bus_a.iBusMISO = '0;
        bus_a.iBusInterrupt = 1'b0;
        bus_b.iBusMISO = '0;
        bus_b.iBusInterrupt = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_interrupt();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
